// File: rtl/hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline: EX forwarding selects,
// load-use / redirect / cache-miss stall sequencing, miss watchdog and perf counters.
module hazard_ctrl #(
    parameter int CNT_W        = 32,
    parameter int MISS_TIMEOUT = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       rs1D_i,
    input  logic [4:0]       rs2D_i,
    input  logic [4:0]       rs1E_i,
    input  logic [4:0]       rs2E_i,
    input  logic [4:0]       rdE_i,
    input  logic             LoadE_i,
    input  logic [4:0]       rdM_i,
    input  logic             RegWriteM_i,
    input  logic [4:0]       rdW_i,
    input  logic             RegWriteW_i,
    input  logic             PCSrcE_i,
    input  logic             CacheMissM_i,
    input  logic             CacheReadyM_i,
    output logic [1:0]       ForwardAE_o,
    output logic [1:0]       ForwardBE_o,
    output logic             StallF_o,
    output logic             StallD_o,
    output logic             StallE_o,
    output logic             StallM_o,
    output logic             FlushD_o,
    output logic             FlushE_o,
    output logic             BubbleW_o,
    output logic             MissTimeout_o,
    output logic [CNT_W-1:0] StallCycles_o,
    output logic [CNT_W-1:0] MissCycles_o
);

    localparam int                WD_W    = (MISS_TIMEOUT < 2) ? 1 : $clog2(MISS_TIMEOUT + 1);
    localparam logic [WD_W-1:0]   WD_MAX  = WD_W'(MISS_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MISS_WAIT = 2'd1,
        RESUME    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              lu;
    logic              miss_stall;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic              timeout_q;
    logic [CNT_W-1:0]  stall_cnt_q, miss_cnt_q;

    // MEM result is younger than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       wr_m, input logic [4:0] rd_m,
                                           input logic       wr_w, input logic [4:0] rd_w);
        if (rs == 5'd0)                 return 2'b00;
        else if (wr_m && rd_m == rs)    return 2'b10;
        else if (wr_w && rd_w == rs)    return 2'b01;
        else                            return 2'b00;
    endfunction

    always_comb begin
        lu         = LoadE_i && (rdE_i != 5'd0) && ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));
        miss_stall = (state_q == MISS_WAIT) ||
                     ((state_q == RUN) && CacheMissM_i && !CacheReadyM_i);
    end

    // NOTE: every output gets a default before any branch, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:       if (CacheMissM_i && !CacheReadyM_i) state_d = MISS_WAIT;
            MISS_WAIT: if (CacheReadyM_i)                  state_d = RESUME;
            RESUME:                                        state_d = RUN;
            default:                                       state_d = RUN;
        endcase

        wd_cnt_d = wd_cnt_q;
        if (state_q == RUN && state_d == MISS_WAIT)
            wd_cnt_d = WD_W'(1);
        else if (state_q == MISS_WAIT && state_d == MISS_WAIT && wd_cnt_q != WD_MAX)
            wd_cnt_d = wd_cnt_q + WD_W'(1);
    end

    always_comb begin
        ForwardAE_o = 2'b00;
        ForwardBE_o = 2'b00;
        StallF_o    = 1'b0;
        StallD_o    = 1'b0;
        StallE_o    = 1'b0;
        StallM_o    = 1'b0;
        FlushD_o    = 1'b0;
        FlushE_o    = 1'b0;
        BubbleW_o   = 1'b0;
        if (!rst_i) begin
            ForwardAE_o = fwd_sel(rs1E_i, RegWriteM_i, rdM_i, RegWriteW_i, rdW_i);
            ForwardBE_o = fwd_sel(rs2E_i, RegWriteM_i, rdM_i, RegWriteW_i, rdW_i);
            // A held EX instruction re-raises its redirect once the miss releases.
            if (miss_stall) begin
                StallF_o  = 1'b1;
                StallD_o  = 1'b1;
                StallE_o  = 1'b1;
                StallM_o  = 1'b1;
                BubbleW_o = 1'b1;
            end else if (PCSrcE_i) begin
                FlushD_o = 1'b1;
                FlushE_o = 1'b1;
            end else if (lu) begin
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                FlushE_o = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (StallF_o && stall_cnt_q != CNT_MAX)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (state_q == MISS_WAIT && miss_cnt_q != CNT_MAX)
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            if (MISS_TIMEOUT > 0) begin
                wd_cnt_q <= wd_cnt_d;
                if (state_d == MISS_WAIT && wd_cnt_d == WD_MAX)
                    timeout_q <= 1'b1;
            end
        end
    end

    assign MissTimeout_o = timeout_q;
    assign StallCycles_o = stall_cnt_q;
    assign MissCycles_o  = miss_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_hazard_ctrl;

    localparam int      T       = 4;
    localparam longint  MAX32   = 64'hFFFF_FFFF;
    localparam longint  MAX3    = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       LoadE, RegWriteM, RegWriteW, PCSrcE, miss, ready;

    logic [1:0]  fa, fb;
    logic        sf, sd, se, sm, fd, fe, bw, to;
    logic [31:0] stc, msc;

    logic [1:0]  s_fa, s_fb;
    logic        s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_bw, s_to;
    logic [2:0]  s_stc, s_msc;

    hazard_ctrl #(.CNT_W(32), .MISS_TIMEOUT(T)) dut (
        .clk_i(clk), .rst_i(rst),
        .rs1D_i(rs1D), .rs2D_i(rs2D), .rs1E_i(rs1E), .rs2E_i(rs2E),
        .rdE_i(rdE), .LoadE_i(LoadE), .rdM_i(rdM), .RegWriteM_i(RegWriteM),
        .rdW_i(rdW), .RegWriteW_i(RegWriteW), .PCSrcE_i(PCSrcE),
        .CacheMissM_i(miss), .CacheReadyM_i(ready),
        .ForwardAE_o(fa), .ForwardBE_o(fb),
        .StallF_o(sf), .StallD_o(sd), .StallE_o(se), .StallM_o(sm),
        .FlushD_o(fd), .FlushE_o(fe), .BubbleW_o(bw), .MissTimeout_o(to),
        .StallCycles_o(stc), .MissCycles_o(msc)
    );

    // Narrow counters, watchdog disabled: exercises saturation and the disable path.
    hazard_ctrl #(.CNT_W(3), .MISS_TIMEOUT(0)) dut_s (
        .clk_i(clk), .rst_i(rst),
        .rs1D_i(rs1D), .rs2D_i(rs2D), .rs1E_i(rs1E), .rs2E_i(rs2E),
        .rdE_i(rdE), .LoadE_i(LoadE), .rdM_i(rdM), .RegWriteM_i(RegWriteM),
        .rdW_i(rdW), .RegWriteW_i(RegWriteW), .PCSrcE_i(PCSrcE),
        .CacheMissM_i(miss), .CacheReadyM_i(ready),
        .ForwardAE_o(s_fa), .ForwardBE_o(s_fb),
        .StallF_o(s_sf), .StallD_o(s_sd), .StallE_o(s_se), .StallM_o(s_sm),
        .FlushD_o(s_fd), .FlushE_o(s_fe), .BubbleW_o(s_bw), .MissTimeout_o(s_to),
        .StallCycles_o(s_stc), .MissCycles_o(s_msc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: waiting on a miss, one-cycle release, plain event counts.
    bit     m_wait, m_resume, m_to, e_stallf;
    longint m_stalls, m_misses;
    int     m_k;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (RegWriteM && rdM == rs) return 2'b10;
        if (RegWriteW && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_clear();
        m_wait = 0; m_resume = 0; m_to = 0; m_k = 0;
        m_stalls = 0; m_misses = 0;
    endtask

    task automatic sample();
        logic [1:0] e_fa, e_fb, e_fl;
        logic [3:0] e_st;
        logic       e_bw, lu, ms;
        @(negedge clk);
        lu   = LoadE && rdE != 5'd0 && (rdE == rs1D || rdE == rs2D);
        ms   = m_wait || (!m_resume && miss && !ready);
        e_fa = 2'b00; e_fb = 2'b00; e_fl = 2'b00; e_st = 4'b0000; e_bw = 1'b0;
        if (!rst) begin
            e_fa = ref_fwd(rs1E);
            e_fb = ref_fwd(rs2E);
            if (ms) begin
                e_st = 4'b1111; e_bw = 1'b1;
            end else if (PCSrcE) begin
                e_fl = 2'b11;
            end else if (lu) begin
                e_st = 4'b1100; e_fl = 2'b01;
            end
        end
        e_stallf = e_st[3];
        check("fwdA",      fa, e_fa);
        check("fwdB",      fb, e_fb);
        check("stalls",    {sf, sd, se, sm}, e_st);
        check("flushes",   {fd, fe}, e_fl);
        check("bubbleW",   bw, e_bw);
        check("timeout",   to, m_to);
        check("stall_cnt", stc, sat(m_stalls, MAX32));
        check("miss_cnt",  msc, sat(m_misses, MAX32));
        check("s_ctrl",    {s_fa, s_fb, s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_bw},
                           {e_fa, e_fb, e_st, e_fl, e_bw});
        check("s_timeout", s_to, 0);
        check("s_stall_cnt_sat", s_stc, sat(m_stalls, MAX3));
        check("s_miss_cnt_sat",  s_msc, sat(m_misses, MAX3));
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (e_stallf) m_stalls++;
            if (m_wait)   m_misses++;
            if (m_wait) begin
                if (ready) begin
                    m_wait = 0; m_resume = 1;
                end else begin
                    m_k++;
                    if (m_k >= T) m_to = 1;
                end
            end else if (m_resume) begin
                m_resume = 0;
            end else if (miss && !ready) begin
                m_wait = 1; m_k = 1;
                if (m_k >= T) m_to = 1;
            end
        end
        #1;
    endtask

    task automatic set_idle();
        rst = 0; rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        LoadE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; miss = 0; ready = 0;
    endtask

    initial begin
        model_clear();
        set_idle();
        // Reset with every hazard source active: outputs must still be quiet.
        rst = 1; miss = 1; PCSrcE = 1; LoadE = 1; rdE = 7; rs1D = 7;
        RegWriteM = 1; rdM = 3; rs1E = 3;
        @(posedge clk); model_clear(); #1;
        sample();
        check("lit_rst_ctrl", {sf, sd, se, sm, fd, fe, bw}, 7'b0);
        check("lit_rst_fwd", fa, 2'b00);
        advance();

        set_idle();
        sample();
        check("lit_cnt_after_rst", {stc, msc}, 64'd0);
        advance();

        // Forwarding priority.
        RegWriteM = 1; rdM = 5; RegWriteW = 1; rdW = 5; rs1E = 5;
        sample(); check("lit_fwd_mem", fa, 2'b10); advance();
        RegWriteM = 0;
        sample(); check("lit_fwd_wb", fa, 2'b01); advance();
        RegWriteM = 1; rs1E = 0;
        sample(); check("lit_fwd_x0", fa, 2'b00); advance();

        // Load-use, then x0 destination.
        set_idle(); LoadE = 1; rdE = 7; rs2D = 7;
        sample(); check("lit_lu", {sf, sd, fe, fd}, 4'b1110); check("lit_lu_cnt0", stc, 0); advance();
        set_idle(); LoadE = 1; rdE = 0;
        sample(); check("lit_lu_x0", sf, 0); check("lit_lu_cnt1", stc, 1); advance();

        // Redirect beats load-use.
        set_idle(); LoadE = 1; rdE = 7; rs2D = 7; PCSrcE = 1;
        sample(); check("lit_redirect", {fd, fe, sf}, 3'b110); advance();

        // Miss: ready low for 3 cycles then high; redirect suppressed throughout.
        set_idle(); miss = 1; PCSrcE = 1;
        for (int k = 0; k < 4; k++) begin
            ready = (k == 3);
            sample();
            check("lit_miss_stall", {sf, sd, se, sm, bw}, 5'b11111);
            check("lit_miss_noflush", fd, 0);
            advance();
        end
        // RESUME ignores a new miss.
        PCSrcE = 0; ready = 0;
        sample(); check("lit_resume_ignores_miss", sf, 0); check("lit_miss_cnt3", msc, 3); advance();

        // Same miss now sampled in RUN; watchdog fires from the 4th wait cycle.
        sample(); check("lit_wd_entry", sf, 1); advance();
        for (int k = 1; k <= 6; k++) begin
            ready = (k == 6);
            sample(); check("lit_wd", to, (k >= T)); advance();
        end
        set_idle();
        sample(); check("lit_timeout_sticky", to, 1); advance();

        // Zero-wait hit stays in RUN.
        miss = 1; ready = 1;
        sample(); check("lit_zero_wait", sf, 0); advance();
        set_idle();
        sample(); check("lit_zero_wait_run", sf, 0); advance();

        // Reset in the middle of a miss.
        miss = 1; ready = 0;
        sample(); advance();
        sample(); advance();
        rst = 1;
        sample(); check("lit_rst_mid_miss", {sf, sd, se, sm, fd, fe, bw}, 7'b0); advance();
        set_idle();
        sample();
        check("lit_rst_clears", {stc, msc}, 64'd0);
        check("lit_rst_clears_to", to, 0);
        check("lit_rst_run", sf, 0);
        advance();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            rs1D      = 5'($urandom_range(0, 7));
            rs2D      = 5'($urandom_range(0, 7));
            rs1E      = 5'($urandom_range(0, 7));
            rs2E      = 5'($urandom_range(0, 7));
            rdE       = 5'($urandom_range(0, 7));
            rdM       = 5'($urandom_range(0, 7));
            rdW       = 5'($urandom_range(0, 7));
            LoadE     = 1'($urandom_range(0, 1));
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            PCSrcE    = ($urandom_range(0, 3) == 0);
            miss      = ($urandom_range(0, 3) == 0);
            ready     = ($urandom_range(0, 2) == 0);
            sample();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard controller for the 5-stage pipeline.
- Drives the EX-stage forwarding selects (ForwardAE/ForwardBE).
- Detects load-use hazards and control redirects, and sequences stage stall/flush enables.
- Runs a data-cache-miss wait FSM with a ready handshake, a miss watchdog and saturating stall counters.

Parameters:
- CNT_W, 32, width of stall/miss performance counters.
- MISS_TIMEOUT, 0, max cycles in MISS_WAIT before MissTimeout_o sets; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- rs1D_i, rs2D_i  in  5  source registers of the instruction in ID.
- rs1E_i, rs2E_i  in  5  source registers of the instruction in EX.
- rdE_i  in  5  destination register in EX.
- LoadE_i  in  1  EX instruction is a load (write source = memory).
- rdM_i  in  5  destination register in MEM.
- RegWriteM_i  in  1  MEM instruction writes the register file.
- rdW_i  in  5  destination register in WB.
- RegWriteW_i  in  1  WB instruction writes the register file.
- PCSrcE_i  in  1  taken branch / jump / ret resolved in EX.
- CacheMissM_i  in  1  MEM access missed; held until serviced.
- CacheReadyM_i  in  1  miss data valid this cycle.
- ForwardAE_o, ForwardBE_o  out  2  00=RD1E/RD2E, 01=ResultW, 10=ALUResultM.
- StallF_o, StallD_o, StallE_o, StallM_o  out  1  hold the corresponding pipeline register.
- FlushD_o, FlushE_o  out  1  clear IF/ID and ID/EX to a bubble.
- BubbleW_o  out  1  clear MEM/WB (no writeback) this cycle.
- MissTimeout_o  out  1  sticky watchdog error.
- StallCycles_o  out  CNT_W  cycles with StallF_o=1, saturating.
- MissCycles_o  out  CNT_W  cycles spent in MISS_WAIT, saturating.

Behaviour:
- Forwarding (combinational), per operand X in {1,2}:
  - 10 if RegWriteM_i && rdM_i==rsXE_i && rsXE_i!=0.
  - else 01 if RegWriteW_i && rdW_i==rsXE_i && rsXE_i!=0.
  - else 00.
  - MEM beats WB when both match.
- Load-use: lu = LoadE_i && rdE_i!=0 && (rdE_i==rs1D_i || rdE_i==rs2D_i).
- FSM states: RUN, MISS_WAIT, RESUME. Reset state RUN.
  - RUN -> MISS_WAIT when CacheMissM_i=1 and CacheReadyM_i=0.
  - RUN with CacheMissM_i && CacheReadyM_i in the same cycle: zero-wait hit, stay in RUN, no stall.
  - MISS_WAIT -> RESUME when CacheReadyM_i=1.
  - RESUME -> RUN unconditionally (one cycle). A new CacheMissM_i in RESUME is ignored. It is next sampled in RUN.
- Output priority (combinational from state and inputs): miss > redirect > load-use.
  - MISS_WAIT, or RUN with a miss that is not ready:
    - StallF_o, StallD_o, StallE_o and StallM_o = 1.
    - BubbleW_o = 1.
    - FlushD_o and FlushE_o = 0; PCSrcE_i is ignored.
    - The EX instruction is held, so the redirect re-evaluates after release.
  - Otherwise, if PCSrcE_i: FlushD_o = FlushE_o = 1; all stalls 0; lu ignored (wrong-path).
  - Otherwise, if lu: StallF_o = StallD_o = 1 and FlushE_o = 1.
  - Otherwise: all stall, flush and bubble outputs 0.
  - RESUME: no miss stall; the redirect and load-use rules apply normally.
- Watchdog (active only when MISS_TIMEOUT>0):
  - Counter cleared on MISS_WAIT entry, increments each MISS_WAIT cycle.
  - When it reaches MISS_TIMEOUT, MissTimeout_o sets and stays set until rst_i.
  - The FSM keeps waiting; the watchdog does not abort the miss.
- Performance counters:
  - Registered; increment by 1 on the cycle after the condition is true.
  - Saturate at 2^CNT_W-1 with no wrap.
- Reset (synchronous, rst_i=1 on a rising edge):
  - State returns to RUN; counters, watchdog and MissTimeout_o clear to 0.
  - Reset mid-miss abandons the miss and returns to RUN next cycle.
  - While rst_i=1, all stall, flush and bubble outputs are forced to 0 and forwards to 00.

Test Plan:
- Forwarding: MEM writes x5 (RegWriteM=1, rdM=5) and WB writes x5 (RegWriteW=1, rdW=5) with rs1E=5 -> ForwardAE=10. With RegWriteM=0 -> ForwardAE=01. With rs1E=0 -> ForwardAE=00.
- Load-use: LoadE=1, rdE=7, rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. StallCycles increments 0->1. With rdE=0 -> no stall.
- Redirect versus load-use: lu true and PCSrcE=1 in the same cycle -> FlushD=FlushE=1 and StallF=0.
- Miss handshake: CacheMissM=1 held with CacheReady low for 3 cycles, then high.
  - Stalls and BubbleW are high for 4 cycles (RUN entry cycle plus 3 MISS_WAIT cycles).
  - Then RESUME, then RUN.
  - MissCycles=3.
  - PCSrcE=1 during the miss -> FlushD=0 throughout.
- Zero-wait hit: CacheMissM=CacheReadyM=1 in RUN -> no stall, state stays RUN.
- Watchdog and reset: MISS_TIMEOUT=4 with ready held low for 6 cycles -> MissTimeout=1 from the 4th MISS_WAIT cycle, stays set after ready. Asserting rst_i mid-miss -> RUN, all outputs 0, counters 0 next cycle.
